// File: rtl/booth_mac_acc.sv
// Signed MAC back end: sums len Booth products into an ACC_W accumulator; prod_ready from cycle T+1, sum_valid at T+len+1.
// One product per cycle, prod_valid low stalls, sum held until sum_ready; BOOTH_MAC_SAT_EN selects saturating adds.
module booth_mac_acc #(
  parameter int ACC_W = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  input  logic [63:0]      prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] remaining;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_res;
  logic [ACC_W-1:0] acc_next;
  logic             add_ovf;

  assign prod_ext = ACC_W'($signed(prod));
  assign add_res  = acc + prod_ext;

  // Same-sign addends whose result flips sign: the true sum left the ACC_W range.
  assign add_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (add_res[ACC_W-1] != acc[ACC_W-1]);

`ifdef BOOTH_MAC_SAT_EN
  always_comb begin
    acc_next = add_res;
    if (add_ovf) begin
      acc_next = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign acc_next = add_res;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      remaining <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            remaining <= len;
            state     <= (len == '0) ? S_HOLD : S_ACC;
          end
        end
        S_ACC: begin
          if (prod_valid) begin
            acc       <= acc_next;
            count     <= count + CNT_W'(1);
            remaining <= remaining - CNT_W'(1);
            if (add_ovf) overflow <= 1'b1;
            if (remaining == CNT_W'(1)) state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (sum_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs decode from state alone so no input reaches them combinationally.
  assign busy       = (state != S_IDLE);
  assign prod_ready = (state == S_ACC);
  assign sum_valid  = (state == S_HOLD);
  assign sum        = acc;

endmodule

// File: tb/tb_booth_mac_acc.sv
// Scoreboard bench for booth_mac_acc: expected totals queued at job start, compared when the sum is accepted.
module tb_booth_mac_acc;
  localparam int ACC_W = 64;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             busy;
  logic [63:0]      prod;
  logic             prod_valid;
  logic             prod_ready;
  logic [ACC_W-1:0] sum;
  logic             sum_valid;
  logic             sum_ready;
  logic [CNT_W-1:0] count;
  logic             overflow;

  booth_mac_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .count(count), .overflow(overflow)
  );

  typedef struct packed {
    logic [63:0] sum;
    logic [7:0]  count;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;
  logic [63:0] pv[256];
  int          pg[256];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference add: 64-bit two's complement with wrap or clamp, returns {ovf, result}.
  function automatic logic [64:0] mdl(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] s;
    logic        o;
    s = a + b;
    o = (a[63] == b[63]) && (s[63] != a[63]);
`ifdef BOOTH_MAC_SAT_EN
    if (o) s = a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    return {o, s};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && sum_valid && sum_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_sum", {63'd0, sum_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sum", sum, e.sum);
        chk("count", {56'd0, count}, {56'd0, e.count});
        chk("overflow", {63'd0, overflow}, {63'd0, e.ovf});
      end
    end
  end

  // n products from pv/pg, then hold_cyc cycles of sum_ready low; poke drives start/prod_valid noise while held.
  task automatic do_job(input int n, input int hold_cyc, input bit poke);
    logic [63:0] a;
    logic        o;
    logic [64:0] r;
    int          g;
    int          c0;
    exp_t        e;
    a = '0; o = 1'b0; g = 0;
    for (int i = 0; i < n; i++) begin
      r = mdl(a, pv[i]);
      a = r[63:0];
      o = o | r[64];
      g += pg[i];
    end
    e.sum = a; e.count = n[7:0]; e.ovf = o;
    sb.push_back(e);

    start = 1'b1; len = n[7:0];
    @(posedge clk); #1;
    start = 1'b0; c0 = cyc;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < pg[i]; k++) begin
        prod_valid = 1'b0; prod = {$urandom, $urandom};
        @(posedge clk); #1;
        chk("stall_count", {56'd0, count}, i);
      end
      prod_valid = 1'b1; prod = pv[i];
      chk("prod_ready_acc", {63'd0, prod_ready}, 64'd1);
      @(posedge clk); #1;
    end
    prod_valid = 1'b0;
    chk("latency", cyc - c0, n + g);
    chk("sum_valid_rise", {63'd0, sum_valid}, 64'd1);
    chk("busy_hold", {63'd0, busy}, 64'd1);
    if (n == 0) chk("prod_ready_empty", {63'd0, prod_ready}, 64'd0);

    for (int h = 0; h < hold_cyc; h++) begin
      sum_ready = 1'b0; start = poke; len = 8'd3; prod_valid = poke;
      prod = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("sum_stable", sum, a);
      chk("prod_ready_hold", {63'd0, prod_ready}, 64'd0);
      chk("sum_valid_hold", {63'd0, sum_valid}, 64'd1);
    end
    sum_ready = 1'b1; start = poke; prod_valid = 1'b0;
    @(posedge clk); #1;
    sum_ready = 1'b0; start = 1'b0;
    chk("busy_drop", {63'd0, busy}, 64'd0);
    chk("sum_valid_drop", {63'd0, sum_valid}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; prod = '0; prod_valid = 1'b0; sum_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin pv[i] = '0; pg[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sum", sum, 64'd0);
    chk("rst_sum_valid", {63'd0, sum_valid}, 64'd0);
    chk("rst_prod_ready", {63'd0, prod_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_count", {56'd0, count}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic: 6 + (-2) + 10 = 14
    pv[0] = 64'd6; pv[1] = 64'hFFFF_FFFF_FFFF_FFFE; pv[2] = 64'd10;
    do_job(3, 0, 1'b0);

    // Empty job with noise on start/prod_valid while held
    do_job(0, 2, 1'b1);

    // Positive overflow followed straight away by a clean job
    pv[0] = 64'h4000_0000_0000_0000; pv[1] = 64'h4000_0000_0000_0000;
    do_job(2, 0, 1'b0);
    pv[0] = 64'd5;
    do_job(1, 0, 1'b0);

    // Negative overflow
    pv[0] = 64'h8000_0000_0000_0001; pv[1] = 64'h8000_0000_0000_0000; pv[2] = 64'd3;
    do_job(3, 1, 1'b0);

    // Backpressure on both sides
    pv[0] = 64'd100; pv[1] = 64'hFFFF_FFFF_FFFF_FFE2; pg[1] = 3;
    do_job(2, 5, 1'b1);
    pg[1] = 0;

    // Reset after two of four products
    start = 1'b1; len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prod_valid = 1'b1; prod = 64'd1000 + 64'(i);
      @(posedge clk); #1;
    end
    prod_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_sum", sum, 64'd0);
    chk("abort_sum_valid", {63'd0, sum_valid}, 64'd0);
    chk("abort_prod_ready", {63'd0, prod_ready}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_count", {56'd0, count}, 64'd0);
    chk("abort_overflow", {63'd0, overflow}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    pv[0] = 64'hFFFF_FFFF_FFFF_FFF9;
    do_job(1, 0, 1'b0);

    // Maximum length: count must reach 255 without wrapping
    for (int i = 0; i < 255; i++) pv[i] = 64'(i);
    do_job(255, 0, 1'b0);

    // Random products and stalls
    for (int j = 0; j < 4; j++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        pv[i] = {$urandom, $urandom};
        pg[i] = $urandom_range(0, 2);
      end
      do_job(n, $urandom_range(0, 3), 1'b1);
      for (int i = 0; i < n; i++) pg[i] = 0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/booth_mac_acc.md
# booth_mac_acc

Signed multiply-accumulate back end that consumes 64-bit two's-complement products from the combinational 32x32 Booth multiplier. It sums a programmable number of products into an accumulator and returns the total through a valid/ready handshake. It sits directly downstream of the multiplier's `result` bus; the upstream operand sequencer drives `prod`/`prod_valid` from the multiplier output.

## Interface
- `ACC_W`, default 64: accumulator and sum width. Must be ≥ 64. Products are sign-extended to this width.
- `CNT_W`, default 8: width of the product-count field.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `rst` in, 1: reset, synchronous and active-high.
- `start` in, 1: begin a new accumulation. Sampled only in IDLE.
- `len` in, CNT_W: number of products to accumulate. Sampled with `start`.
- `busy` out, 1: high whenever the state is not IDLE.
- `prod` in, 64: signed product from the multiplier.
- `prod_valid` in, 1: `prod` is valid.
- `prod_ready` out, 1: block accepts `prod` this cycle.
- `sum` out, ACC_W: accumulated result. Valid while `sum_valid` is high.
- `sum_valid` out, 1: result available.
- `sum_ready` in, 1: consumer accepts `sum`.
- `count` out, CNT_W: number of products accepted in the current job.
- `overflow` out, 1: sticky signed-overflow flag for the current job.

## Operation
- States: IDLE, ACC, HOLD.
- **IDLE**
  - `start`=1 and `len`≠0: clear acc, `count` and `overflow`; load remaining=`len`; go to ACC.
  - `start`=1 and `len`=0: clear acc, `count` and `overflow`; go directly to HOLD, giving `sum`=0.
- **ACC**
  - `prod_ready`=1.
  - On a handshake (`prod_valid` and `prod_ready`): acc ← acc + sext(`prod`); `count`++; remaining--.
  - The handshake that accepts the `len`-th product moves the block to HOLD.
- **HOLD**
  - `sum_valid`=1; `sum`=acc, held stable.
  - `prod_ready`=0.
  - On `sum_ready`=1: return to IDLE.
  - `count` and `overflow` hold until the next `start`.
- `start` is ignored in ACC and HOLD. `prod_valid` is ignored outside ACC.
- Overflow detection: signed overflow of the ACC_W-bit add, i.e. both addends have the same sign and the result sign differs. Detection sets the sticky `overflow` flag.
- Arithmetic is pure two's complement. No rounding and no truncation of `prod`.

## Timing
- Reset values: state=IDLE, acc=0, `sum`=0, `sum_valid`=0, `prod_ready`=0, `busy`=0, `count`=0, `overflow`=0.
- `prod_ready`, `sum_valid` and `busy` decode from registered state only; no combinational path from inputs.
- Throughput: one product per cycle in ACC.
- Latency, with `start` accepted at edge T:
  - `prod_ready` goes high in cycle T+1.
  - With no stalls, products are accepted at T+1 … T+len.
  - `sum_valid` goes high in cycle T+len+1.
- `len`=0: `sum_valid` goes high in cycle T+1.
- `prod_valid` low stalls ACC with no state change.
- `sum_ready` low holds HOLD indefinitely; `sum` does not change.
- `sum_ready` high in the first HOLD cycle: `sum_valid` is high for one cycle and `busy` drops the next cycle.
- `start` high in the same cycle as the IDLE return has no effect. A new job needs `start` in IDLE.
- `rst` mid-job: aborts on the next edge and reloads the reset values. No `sum` is emitted.
- `len`=2^CNT_W−1 (maximum): `count` reaches that value without wrapping.

## Configuration
- `BOOTH_MAC_SAT_EN` defined:
  - On overflow, acc clamps to 2^(ACC_W−1)−1 (positive overflow) or −2^(ACC_W−1) (negative overflow).
  - Later adds continue from the clamped value.
  - `overflow` is still set.
- Not defined: acc wraps modulo 2^ACC_W; `overflow` is still set.
- Both variants have identical ports and timing.

## Test plan
- **Basic accumulation:** `len`=3, products 6, 0xFFFF_FFFF_FFFF_FFFE (−2), 10 back-to-back → `sum_valid` at T+4, `sum`=14, `count`=3, `overflow`=0.
- **Empty job:** `len`=0 → `sum_valid` at T+1, `sum`=0, `count`=0. Any `prod_valid` pulses are ignored.
- **Positive overflow, ACC_W=64:** two products of 0x4000_0000_0000_0000.
  - Without macro: `sum`=0x8000_0000_0000_0000, `overflow`=1.
  - With `BOOTH_MAC_SAT_EN`: `sum`=0x7FFF_FFFF_FFFF_FFFF, `overflow`=1.
- **Backpressure:** `len`=2 with `prod_valid` low for 3 cycles between products → `sum`=correct, result delayed 3 cycles. In HOLD, `sum_ready` low for 5 cycles → `sum` stable, `prod_ready`=0, `start` pulses ignored.
- **Reset mid-job:** `len`=4, assert `rst` after 2 products → next cycle all outputs at reset values, no `sum_valid`. A new job with `len`=1 and `prod`=−7 → `sum`=−7.
- **Back-to-back jobs:** accept `sum`, then `start` next IDLE cycle with `len`=1 and `prod`=5 → `sum`=5, `overflow` cleared from the prior job.
